// File: rtl/ldpc_llr_framer.sv
// LLR framer for the LDPC decoder: converts incoming soft LLRs to saturated 8-bit values,
// collects them in a ping-pong frame buffer and replays each full frame as one gap-free burst.
module ldpc_llr_framer #(
    parameter int unsigned FRAME_LEN = 8640,
    parameter int unsigned LLR_W_IN  = 12,
    parameter int unsigned SHIFT     = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                llr_valid,
    input  logic [LLR_W_IN-1:0] llr_din,
    output logic                llr_ready,
    output logic                frame_start,
    output logic [7:0]          symbol_dout,
    input  logic                dec_frame_finish,
    output logic [15:0]         sat_count
);
    localparam int unsigned IdxW  = $clog2(FRAME_LEN);
    localparam int unsigned AddrW = $clog2(2 * FRAME_LEN);
    localparam logic [IdxW-1:0]            LastIdx = IdxW'(FRAME_LEN - 1);
    localparam logic [AddrW-1:0]           BankOfs = AddrW'(FRAME_LEN);
    localparam logic signed [LLR_W_IN-1:0] SatHi   = LLR_W_IN'(127);
    localparam logic signed [LLR_W_IN-1:0] SatLo   = LLR_W_IN'(-127);

    typedef enum logic [1:0] {StIdle, StStart, StBurst, StWait} state_e;

    state_e            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [1:0]        full_q, full_d;
    logic [15:0]       sat_count_q, sat_count_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
    logic              dec_busy_q, dec_busy_d;
    logic [7:0]        rdata_q;
    logic [7:0]        mem [2*FRAME_LEN];

    logic                       accept;
    logic                       burst_last;
    logic signed [LLR_W_IN-1:0] shifted;
    logic [7:0]                 conv_val;
    logic                       clamped;
    logic [IdxW-1:0]            rd_off;
    logic [AddrW-1:0]           wr_addr;
    logic [AddrW-1:0]           rd_addr;

    assign llr_ready  = !full_q[wr_bank_q];
    assign accept     = llr_valid && llr_ready;
    assign burst_last = (state_q == StBurst) && (rd_idx_q == LastIdx);
    assign sat_count  = sat_count_q;
    assign shifted    = $signed(llr_din) >>> SHIFT;

    // Symmetric clamp to [-127, +127] so -128 never reaches the decoder
    always_comb begin
        conv_val = shifted[7:0];
        clamped  = 1'b0;
        if (shifted > SatHi) begin
            conv_val = 8'h7F;
            clamped  = 1'b1;
        end else if (shifted < SatLo) begin
            conv_val = 8'h81;
            clamped  = 1'b1;
        end
    end

    // Read address runs one sample ahead of the output to hide the RAM latency
    assign rd_off  = (state_q == StBurst && rd_idx_q != LastIdx) ? rd_idx_q + IdxW'(1) : '0;
    assign rd_addr = (rd_bank_q ? BankOfs : '0) + AddrW'(rd_off);
    assign wr_addr = (wr_bank_q ? BankOfs : '0) + AddrW'(wr_idx_q);

    // Frame buffer: simple dual-port RAM with registered read
    always_ff @(posedge clk_in) begin
        if (accept) begin
            mem[wr_addr] <= conv_val;
        end
        rdata_q <= mem[rd_addr];
    end

    // Write pointer, bank flags, burst counter and decoder-busy bookkeeping
    always_comb begin
        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        full_d      = full_q;
        sat_count_d = sat_count_q;
        rd_idx_d    = rd_idx_q;
        rd_bank_d   = rd_bank_q;
        dec_busy_d  = dec_busy_q;
        if (accept) begin
            if (clamped && sat_count_q != 16'hFFFF) begin
                sat_count_d = sat_count_q + 16'd1;
            end
            if (wr_idx_q == LastIdx) begin
                full_d[wr_bank_q] = 1'b1;
                wr_idx_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IdxW'(1);
            end
        end
        // The bank is released at burst end so the next frame can fill during decode
        unique case (state_q)
            StStart: begin
                dec_busy_d = 1'b1;
                rd_idx_d   = '0;
            end
            StBurst: begin
                if (burst_last) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    rd_idx_d          = '0;
                end else begin
                    rd_idx_d = rd_idx_q + IdxW'(1);
                end
            end
            StWait: begin
                if (dec_frame_finish) begin
                    dec_busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            wr_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            sat_count_q <= '0;
            rd_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            dec_busy_q  <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            sat_count_q <= sat_count_d;
            rd_idx_q    <= rd_idx_d;
            rd_bank_q   <= rd_bank_d;
            dec_busy_q  <= dec_busy_d;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (full_q[rd_bank_q] && !dec_busy_q) state_d = StStart;
            StStart: state_d = StBurst;
            StBurst: if (burst_last) state_d = StWait;
            StWait:  if (dec_frame_finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read FSM outputs; symbols are forced to zero outside the burst
    always_comb begin
        frame_start = (state_q == StStart);
        symbol_dout = (state_q == StBurst) ? rdata_q : 8'h00;
    end

endmodule
